// File: rtl/bitmap_index_encoder.sv
// bitmap_index_encoder
//   Accepts an N-bit bitmap over a valid/ready handshake and replays the
//   index of every set bit, one beat per output handshake. An all-zero
//   bitmap produces a single beat flagged with out_none.
//   Optional build macro BITMAP_ENCODER_MSB_FIRST_EN switches the scan
//   order from lowest-set-bit first to highest-set-bit first.
//   All outputs are decoded from r_state/r_pending only, so there is no
//   combinational path from the input side to the output side.
module bitmap_index_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_index,
  output logic         out_last,
  output logic         out_none,
  output logic         busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]   r_state;
  logic [N-1:0] r_pending;

  logic         w_emit;
  logic         w_fire;
  logic         w_single;
  logic         w_empty;
  logic [W-1:0] w_index;
  logic [N-1:0] w_sel;

  assign w_emit = (r_state == S_EMIT);
  assign w_fire = w_emit && out_ready;

  // Priority pick of the next bit to report; the last match in loop order
  // wins, so the loop direction is opposite to the scan order.
  always_comb begin
    w_index = '0;
    w_sel   = '0;
`ifdef BITMAP_ENCODER_MSB_FIRST_EN
    for (int unsigned i = 0; i < N; i++) begin
      if (r_pending[i]) begin
        w_index  = W'(i);
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
`else
    for (int unsigned i = N; i > 0; i--) begin
      if (r_pending[i-1]) begin
        w_index    = W'(i - 1);
        w_sel      = '0;
        w_sel[i-1] = 1'b1;
      end
    end
`endif
  end

  // Final-beat detection: at most one bit left (zero bits covers the
  // all-zero bitmap, which is also a single final beat).
  always_comb begin
    w_empty  = (r_pending == '0);
    w_single = ((r_pending & (r_pending - ONE)) == '0);
  end

  // Output decode; everything is forced to zero outside EMIT.
  always_comb begin
    in_ready  = !w_emit;
    busy      = w_emit;
    out_valid = w_emit;
    out_index = w_emit ? w_index : '0;
    out_last  = w_emit && w_single;
    out_none  = w_emit && w_empty;
  end

  // State and pending-bit register: load on accept, clear one bit per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_pending <= in_bits;
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_fire) begin
            r_pending <= r_pending & ~w_sel;
            if (w_single) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pending <= '0;
        end
      endcase
    end
  end

endmodule
